// File: rtl/skip3_seq_checker.sv
// Receive-side checker for the skip-multiple-of-3 count stream.
// It locks on a zero sample, then checks, decodes and counts errors on every later sample.
//
// state  | meaning
// HUNT   | waiting for a zero sample to lock onto the stream
// LOCKED | tracking; each valid sample is compared with the expected successor
module skip3_seq_checker #(
   parameter int BW       = 8,
   parameter int CW       = 8,
   parameter int MISS_MAX = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   input  logic [BW-1:0] in_data,
   input  logic          err_clr,
   output logic          locked,
   output logic [BW-1:0] idx,
   output logic [BW-1:0] expected,
   output logic          err,
   output logic [CW-1:0] err_cnt
);

   localparam int MW = $clog2(MISS_MAX + 1);
   localparam int PW = BW + (BW % 2);
   localparam int ND = PW / 2;
   localparam int LV = $clog2(ND);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] idx_q, idx_d;
   logic [BW-1:0] exp_q, exp_d;
   logic [MW-1:0] miss_q, miss_d;
   logic [MW-1:0] miss_inc;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          hit, zero, last_miss;

   function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   // 4^k == 1 (mod 3), so the residue is the mod-3 sum of the base-4 digits, folded pairwise.
   function automatic logic [1:0] mod3(input logic [BW-1:0] v);
      logic [PW-1:0] p;
      logic [1:0]    r [ND];
      int            n;
      p = '0;
      p[BW-1:0] = v;
      for (int i = 0; i < ND; i++) r[i] = (p[2*i +: 2] == 2'd3) ? 2'd0 : p[2*i +: 2];
      n = ND;
      for (int lvl = 0; lvl < LV; lvl++) begin
         for (int i = 0; i < ND; i++) begin
            if (2*i + 1 < n)  r[i] = add3(r[2*i], r[2*i + 1]);
            else if (2*i < n) r[i] = r[2*i];
         end
         n = (n + 1) / 2;
      end
      return r[0];
   endfunction

   function automatic logic [BW-1:0] nxt(input logic [BW-1:0] v);
      logic [BW-1:0] vp1;
      vp1 = v + BW'(1);
      if (v == '0)              return BW'(1);
      else if (mod3(vp1) == 2'd0) return v + BW'(2);
      else                      return vp1;
   endfunction

   assign hit       = (in_data == exp_q);
   assign zero      = (in_data == '0);
   assign miss_inc  = miss_q + MW'(1);
   assign last_miss = (miss_inc == MW'(MISS_MAX));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= HUNT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT:    if (in_valid && zero)               state_d = LOCKED;
         LOCKED:  if (in_valid && !hit && last_miss)  state_d = HUNT;
         default: state_d = HUNT;
      endcase
   end

   always_comb begin
      idx_d  = idx_q;
      exp_d  = exp_q;
      miss_d = miss_q;
      cnt_d  = cnt_q;
      err_d  = 1'b0;
      if (in_valid) begin
         if (state_q == HUNT) begin
            if (zero) begin
               idx_d  = '0;
               exp_d  = BW'(1);
               miss_d = '0;
            end
         end else if (hit) begin
            exp_d  = nxt(in_data);
            miss_d = '0;
            idx_d  = zero ? '0 : idx_q + BW'(1);
         end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (!(&cnt_q)) cnt_d = cnt_q + CW'(1);
            // A zero re-anchors exactly like a fresh lock, but still counts as an error.
            if (zero) begin
               idx_d = '0;
               exp_d = BW'(1);
            end else begin
               idx_d = idx_q + BW'(1);
               exp_d = nxt(in_data);
            end
         end
      end
      if (err_clr) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q  <= '0;
         exp_q  <= '0;
         miss_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         exp_q  <= exp_d;
         miss_q <= miss_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign locked   = (state_q == LOCKED);
   assign idx      = idx_q;
   assign expected = exp_q;
   assign err      = err_q;
   assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_skip3_seq_checker.sv
// Self-checking bench for skip3_seq_checker (BW=8, CW=8, MISS_MAX=2).
// A sample-level reference model predicts every output after each clock.
module tb_skip3_seq_checker;

   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic [7:0] in_data;
   logic       err_clr;
   logic       locked;
   logic [7:0] idx;
   logic [7:0] expected;
   logic       err;
   logic [7:0] err_cnt;

   int tests = 0;
   int fails = 0;

   bit m_locked, m_err;
   int m_idx, m_exp, m_miss, m_cnt;

   skip3_seq_checker #(.BW(8), .CW(8), .MISS_MAX(2)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_data  (in_data),
      .err_clr  (err_clr),
      .locked   (locked),
      .idx      (idx),
      .expected (expected),
      .err      (err),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic int succ(input int v);
      if (v == 0) return 1;
      if (((v + 1) % 256) % 3 == 0) return (v + 2) % 256;
      return (v + 1) % 256;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_err = 0; m_idx = 0; m_exp = 0; m_miss = 0; m_cnt = 0;
   endtask

   // Drive one sample for one clock, then advance the reference model.
   task automatic step(input bit v, input int d, input bit clr);
      @(negedge clk);
      in_valid = v;
      in_data  = d[7:0];
      err_clr  = clr;
      @(posedge clk);
      #1;
      m_err = 0;
      if (v) begin
         if (!m_locked) begin
            if (d == 0) begin m_locked = 1; m_exp = 1; m_idx = 0; m_miss = 0; end
         end else if (d == m_exp) begin
            m_exp  = succ(d);
            m_miss = 0;
            m_idx  = (d == 0) ? 0 : (m_idx + 1) % 256;
         end else begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
            m_miss++;
            if (d == 0) begin m_idx = 0; m_exp = 1; end
            else begin m_idx = (m_idx + 1) % 256; m_exp = succ(d); end
            if (m_miss == 2) m_locked = 0;
         end
      end
      if (clr) m_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 0; err_clr = 0; in_data = 8'h00;
      rstn = 0;
      model_reset();
      #2 rstn = 1;
   endtask

   task automatic test_reset();
      rstn = 0; in_valid = 0; in_data = 8'h00; err_clr = 0;
      model_reset();
      #1;
      tests++;
      if ({locked, idx, expected, err, err_cnt} !== 26'd0) begin
         fails++;
         $display("FAIL reset_init: got l=%b i=%0d e=%0d err=%b c=%0d, want all 0", locked, idx, expected, err, err_cnt);
      end
      #11 rstn = 1;
      step(1, 0, 0);
      step(1, 1, 0);
      @(negedge clk);
      #2 rstn = 0;
      #1;
      tests++;
      if ({locked, idx, expected, err, err_cnt} !== 26'd0) begin
         fails++;
         $display("FAIL reset_async: got l=%b i=%0d e=%0d err=%b c=%0d, want all 0", locked, idx, expected, err, err_cnt);
      end
      model_reset();
      #1 rstn = 1;
      for (int k = 0; k < 5; k++) begin
         step(0, $urandom_range(0, 255), 0);
         tests++;
         if ({locked, idx, expected, err, err_cnt} !== 26'd0) begin
            fails++;
            $display("FAIL reset_idle: got l=%b i=%0d e=%0d err=%b c=%0d, want all 0", locked, idx, expected, err, err_cnt);
         end
      end
   endtask

   task automatic test_lock_track();
      int seq [8] = '{5, 0, 1, 2, 4, 5, 7, 8};
      do_reset();
      foreach (seq[k]) begin
         step(1, seq[k], 0);
         tests++;
         if ({locked, idx, expected, err, err_cnt} !== {m_locked, 8'(m_idx), 8'(m_exp), m_err, 8'(m_cnt)}) begin
            fails++;
            $display("FAIL lock_track[%0d]: got l=%b i=%0d e=%0d err=%b c=%0d, want l=%b i=%0d e=%0d err=%b c=%0d",
                     k, locked, idx, expected, err, err_cnt, m_locked, m_idx, m_exp, m_err, m_cnt);
         end
      end
      tests++;
      if (!(locked === 1'b1 && idx === 8'd6 && expected === 8'd10 && err_cnt === 8'd0)) begin
         fails++;
         $display("FAIL lock_track_end: got l=%b i=%0d e=%0d c=%0d, want l=1 i=6 e=10 c=0", locked, idx, expected, err_cnt);
      end
   endtask

   task automatic test_bubbles_wrap();
      int v = 0;
      bit wrapped = 0;
      do_reset();
      step(1, 0, 0);
      for (int n = 0; n < 400; n++) begin
         v = succ(v);
         step(0, $urandom_range(0, 255), 0);
         step(1, v, 0);
         tests++;
         if ({locked, idx, expected, err, err_cnt} !== {m_locked, 8'(m_idx), 8'(m_exp), m_err, 8'(m_cnt)}) begin
            fails++;
            $display("FAIL bubbles v=%0d: got l=%b i=%0d e=%0d err=%b c=%0d, want l=%b i=%0d e=%0d err=%b c=%0d",
                     v, locked, idx, expected, err, err_cnt, m_locked, m_idx, m_exp, m_err, m_cnt);
         end
         if (v == 0) begin
            wrapped = 1;
            tests++;
            if (idx !== 8'd0 || err_cnt !== 8'd0) begin
               fails++;
               $display("FAIL wrap_zero: got i=%0d c=%0d, want i=0 c=0", idx, err_cnt);
            end
         end
         if (wrapped && v == 1) break;
      end
      tests++;
      if (!(idx === 8'd1 && expected === 8'd2 && locked === 1'b1 && err_cnt === 8'd0)) begin
         fails++;
         $display("FAIL wrap_end: got i=%0d e=%0d l=%b c=%0d, want i=1 e=2 l=1 c=0", idx, expected, locked, err_cnt);
      end
   endtask

   task automatic test_single_mismatch();
      int seq [7] = '{0, 1, 2, 4, 6, 7, 8};
      do_reset();
      foreach (seq[k]) begin
         step(1, seq[k], 0);
         tests++;
         if ({locked, idx, expected, err, err_cnt} !== {m_locked, 8'(m_idx), 8'(m_exp), m_err, 8'(m_cnt)}) begin
            fails++;
            $display("FAIL single_mm[%0d]: got l=%b i=%0d e=%0d err=%b c=%0d, want l=%b i=%0d e=%0d err=%b c=%0d",
                     k, locked, idx, expected, err, err_cnt, m_locked, m_idx, m_exp, m_err, m_cnt);
         end
         if (seq[k] == 6) begin
            tests++;
            if (!(err === 1'b1 && err_cnt === 8'd1 && expected === 8'd7 && locked === 1'b1)) begin
               fails++;
               $display("FAIL single_mm_six: got err=%b c=%0d e=%0d l=%b, want err=1 c=1 e=7 l=1", err, err_cnt, expected, locked);
            end
         end
      end
      tests++;
      if (!(err === 1'b0 && err_cnt === 8'd1 && locked === 1'b1 && expected === 8'd10)) begin
         fails++;
         $display("FAIL single_mm_end: got err=%b c=%0d l=%b e=%0d, want err=0 c=1 l=1 e=10", err, err_cnt, locked, expected);
      end
   endtask

   task automatic test_loss_of_lock();
      int seq [6] = '{0, 1, 2, 3, 9, 0};
      do_reset();
      foreach (seq[k]) begin
         step(1, seq[k], 0);
         tests++;
         if ({locked, idx, expected, err, err_cnt} !== {m_locked, 8'(m_idx), 8'(m_exp), m_err, 8'(m_cnt)}) begin
            fails++;
            $display("FAIL loss[%0d]: got l=%b i=%0d e=%0d err=%b c=%0d, want l=%b i=%0d e=%0d err=%b c=%0d",
                     k, locked, idx, expected, err, err_cnt, m_locked, m_idx, m_exp, m_err, m_cnt);
         end
         if (k == 4) begin
            tests++;
            if (!(locked === 1'b0 && err === 1'b1 && err_cnt === 8'd2)) begin
               fails++;
               $display("FAIL loss_drop: got l=%b err=%b c=%0d, want l=0 err=1 c=2", locked, err, err_cnt);
            end
         end
      end
      tests++;
      if (!(locked === 1'b1 && idx === 8'd0 && expected === 8'd1 && err === 1'b0)) begin
         fails++;
         $display("FAIL loss_relock: got l=%b i=%0d e=%0d err=%b, want l=1 i=0 e=1 err=0", locked, idx, expected, err);
      end
   endtask

   task automatic test_saturation_clear();
      do_reset();
      for (int k = 0; k < 300; k++) begin
         step(1, 0, 0);
         step(1, $urandom_range(2, 255), 0);
         tests++;
         if ({locked, idx, expected, err, err_cnt} !== {m_locked, 8'(m_idx), 8'(m_exp), m_err, 8'(m_cnt)}) begin
            fails++;
            $display("FAIL saturate[%0d]: got l=%b i=%0d e=%0d err=%b c=%0d, want l=%b i=%0d e=%0d err=%b c=%0d",
                     k, locked, idx, expected, err, err_cnt, m_locked, m_idx, m_exp, m_err, m_cnt);
         end
      end
      step(1, 0, 0);
      if (!m_locked) step(1, 0, 0);
      step(1, 1, 0);
      tests++;
      if (!(err_cnt === 8'd255 && locked === 1'b1)) begin
         fails++;
         $display("FAIL sat_hold: got c=%0d l=%b, want c=255 l=1", err_cnt, locked);
      end
      step(1, 3, 1);
      tests++;
      if (!(err === 1'b1 && err_cnt === 8'd0)) begin
         fails++;
         $display("FAIL clr_vs_mismatch: got err=%b c=%0d, want err=1 c=0", err, err_cnt);
      end
   endtask

   task automatic test_random();
      int src = 0;
      int d;
      bit v, clr;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 255);
         else d = src;
         if (v && d == src) src = succ(src);
         if ($urandom_range(0, 199) == 0) src = 0;
         step(v, d, clr);
         tests++;
         if ({locked, idx, expected, err, err_cnt} !== {m_locked, 8'(m_idx), 8'(m_exp), m_err, 8'(m_cnt)}) begin
            fails++;
            $display("FAIL random[%0d] v=%b d=%0d: got l=%b i=%0d e=%0d err=%b c=%0d, want l=%b i=%0d e=%0d err=%b c=%0d",
                     k, v, d, locked, idx, expected, err, err_cnt, m_locked, m_idx, m_exp, m_err, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_track();
      test_bubbles_wrap();
      test_single_mismatch();
      test_loss_of_lock();
      test_saturation_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/skip3_seq_checker.md
# skip3_seq_checker

Receive-side checker for the skip-multiple-of-3 count stream: 0, 1, 2, 4, 5, 7, 8, 10, … modulo 2^BW. It consumes valid-qualified sample words from the counter, locks onto the sequence at a zero value, and compares each later sample against the expected successor. It reports the decoded ordinal of each sample, a mismatch pulse, a saturating error count and lock status. It sits at the far end of a link or bus carrying the counter value and serves as a link-integrity monitor and decoder.

## Interface
- BW, 8: sample and ordinal width.
- CW, 8: error counter width.
- MISS_MAX, 2: consecutive mismatches that cause loss of lock; must be 1 or more.

- clk  in  1  clock; everything is sampled on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data is a sample this cycle.
- in_data  in  BW  received count value.
- err_clr  in  1  synchronous clear of err_cnt; has priority over an increment in the same cycle.
- locked  out  1  checker is in LOCKED state.
- idx  out  BW  ordinal of the last accepted sample (0 at the zero value).
- expected  out  BW  next value the checker expects.
- err  out  1  one-cycle pulse on a mismatch in LOCKED.
- err_cnt  out  CW  total mismatches, saturating at 2^CW−1.

## Operation
- Successor function nxt(v), computed mod 2^BW:
  - v == 0 → 1
  - (v+1) mod 3 == 0 → v+2
  - otherwise → v+1
  - For BW=8: nxt(254) = 0 and nxt(250) = 251 → 253.
- The mod-3 test is combinational over the full BW bits. No divider; use a residue reduction tree.
- States:
  - HUNT: waits for lock. On in_valid with in_data == 0 → LOCKED; expected←1, idx←0, miss←0.
  - LOCKED, match (in_valid, in_data == expected):
    - expected←nxt(in_data), miss←0.
    - idx←0 if in_data == 0, else idx←idx+1 (wraps mod 2^BW).
  - LOCKED, mismatch (in_valid, in_data != expected):
    - err←1; err_cnt←err_cnt+1, saturating.
    - expected←nxt(in_data), which re-anchors the checker; idx←idx+1.
    - If in_data == 0, re-anchor as at lock instead (idx←0, expected←1), still with err.
    - miss←miss+1. If miss+1 == MISS_MAX → HUNT; locked drops the next cycle.
- A mismatch to a nonzero multiple of 3 follows the same rule (for example, nxt(6) = 7).
- in_valid low: no state, idx, expected or miss change, and err = 0.
- err_cnt is not cleared by loss of lock; only rstn or err_clr clears it.
- Internal miss counter width is $clog2(MISS_MAX+1).

## Timing
- Reset values: locked=0, idx=0, expected=0, err=0, err_cnt=0, state=HUNT, miss=0.
- All outputs are registered. A sample presented at edge k is reflected in the outputs after edge k, which gives 1-cycle latency.
- err is high exactly one cycle per mismatching sample. Back-to-back mismatches give back-to-back pulses.
- In HUNT, nonzero samples are ignored silently: no err, no count.
- err_clr and a mismatch in the same cycle: err_cnt←0 and err still pulses.
- An asynchronous reset mid-stream returns to HUNT immediately. The first zero sample after reset release relocks.
- Back-to-back in_valid is supported at full rate with no stall.

## Test plan
All scenarios use BW=8, CW=8, MISS_MAX=2.
- Reset:
  - Assert rstn=0 mid-cycle → all outputs 0 asynchronously.
  - Release, then drive in_valid=0 for 5 cycles → outputs unchanged, locked=0.
- Lock and track:
  - Send 5, 0, 1, 2, 4, 5, 7, 8 on consecutive cycles.
  - The 5 is ignored. locked=1 after the 0. idx steps 0..6. expected ends at 10. err never asserts.
- Bubbles and wrap:
  - Send 0, then stream up to 250, 251, 253, 254, 0, 1 with in_valid toggling every other cycle.
  - No err. idx returns to 0 at the second 0 and is 1 after the final 1.
- Single mismatch:
  - While locked after 4, send 6, then 7, 8.
  - err pulses once; err_cnt=1; expected=7 after the 6; locked stays 1; 7 and 8 match.
- Loss of lock:
  - While locked, send 3, 9 consecutively → two err pulses, err_cnt+=2, locked=0.
  - Then 0 → relock; idx=0, expected=1.
- Saturation and clear:
  - Force 300 mismatches by alternating relock 0 and a bad value → err_cnt sticks at 255.
  - Assert err_clr concurrently with a mismatch → err_cnt=0 and err=1.
